// File: rtl/clock_period_meter.sv
// clock_period_meter: measures the half-period of an asynchronous square wave
// in CLOCK cycles and reports it in the programmable divider's flip_count
// encoding (cycles per half-period minus one). Both edge polarities end a
// measurement. The block also tracks lock (LOCK_N consecutive measurements
// within TOL of each other) and loss of signal (TIMEOUT cycles with no edge).
module clock_period_meter #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 100_000_000,
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned TOL     = 0
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         sig_in,
  output logic [W-1:0] half_period,
  output logic         level,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam int unsigned MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [W-1:0]  TIMEOUT_W    = W'(TIMEOUT);
  localparam logic [W-1:0]  TIMEOUT_M1_W = W'(TIMEOUT - 1);
  localparam logic [W-1:0]  TOL_W        = W'(TOL);
  localparam logic [W-1:0]  CNT_ONE      = W'(1);
  localparam logic [MW-1:0] LOCK_N_W     = MW'(LOCK_N);
  localparam logic [MW-1:0] MATCH_ONE    = MW'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           s3_q, s3_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   half_period_q, half_period_d;
  logic           level_q, level_d;
  logic           valid_q, valid_d;
  logic           locked_q, locked_d;
  logic           timeout_q, timeout_d;
  logic [MW-1:0]  match_cnt_q, match_cnt_d;

  logic           sig_edge;
  logic [W-1:0]   abs_diff;
  logic           is_match;
  logic [MW-1:0]  match_next;
  logic           match_kept;

  // Three-flop chain: s1/s2 resynchronise sig_in, s3 remembers the previous level.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign sig_edge = s2_q ^ s3_q;

  // Interval counter: restarts on every edge, otherwise counts up and parks at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (sig_edge) begin
      cnt_d = '0;
    end else if (cnt_q < TIMEOUT_W) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Compare the interval just ending against the previous one (larger minus smaller).
  always_comb begin
    abs_diff   = '0;
    is_match   = 1'b0;
    match_next = match_cnt_q;
    match_kept = 1'b0;
    if (cnt_q >= half_period_q) begin
      abs_diff = cnt_q - half_period_q;
    end else begin
      abs_diff = half_period_q - cnt_q;
    end
    is_match = (abs_diff <= TOL_W);
    if (match_cnt_q == '0) begin
      match_next = MATCH_ONE;
      match_kept = 1'b1;
    end else if (is_match) begin
      match_kept = 1'b1;
      if (match_cnt_q < LOCK_N_W) begin
        match_next = match_cnt_q + MATCH_ONE;
      end
    end else begin
      match_next = MATCH_ONE;
    end
  end

  // FSM next state and output updates; an edge always takes priority over the timeout.
  always_comb begin
    state_d       = state_q;
    half_period_d = half_period_q;
    level_d       = level_q;
    valid_d       = 1'b0;
    locked_d      = locked_q;
    timeout_d     = timeout_q;
    match_cnt_d   = match_cnt_q;
    case (state_q)
      IDLE: begin
        if (sig_edge) begin
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      MEASURE: begin
        if (sig_edge) begin
          half_period_d = cnt_q;
          level_d       = s3_q;
          valid_d       = 1'b1;
          timeout_d     = 1'b0;
          match_cnt_d   = match_next;
          if (!match_kept) begin
            locked_d = 1'b0;
          end else if (match_next == LOCK_N_W) begin
            locked_d = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_M1_W) begin
          state_d     = IDLE;
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; synchronous reset discards any partial interval.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      cnt_q         <= '0;
      half_period_q <= '0;
      level_q       <= 1'b0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
      match_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      s3_q          <= s3_d;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      level_q       <= level_d;
      valid_q       <= valid_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
      match_cnt_q   <= match_cnt_d;
    end
  end

  assign half_period = half_period_q;
  assign level       = level_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule
